bus_arbiter_2m: RTL and testbench
=================================

Name: bus_arbiter_2m

Overview:
- Two-master arbiter and slave decoder for the shared 64-bit system bus.
- Grants bus ownership to one of two masters and routes the owner's address, write strobe and write data to the shared slave port.
- Decodes the owner's address into two slave selects and returns the selected slave's read data.
- Sits between the masters and the existing slave-side memories. It replaces the single-master hookup.

Parameters:
- MAX_HOLD, 8: maximum consecutive owned cycles while the other master is waiting; 0 disables the forced handover.
- S0_BASE, 16'h0000: slave 0 window base; window is S0_BASE..S0_BASE+0xFF.
- S1_BASE, 16'h0100: slave 1 window base; window is S1_BASE..S1_BASE+0xFF.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 bus request.
- m0_wr  in  1  master 0 write (1) / read (0).
- m0_addr  in  16  master 0 address.
- m0_dout  in  64  master 0 write data.
- m1_req, m1_wr, m1_addr, m1_dout: same as the m0_* ports, for master 1.
- m0_grant  out  1  master 0 owns the bus (registered).
- m1_grant  out  1  master 1 owns the bus (registered).
- m_din  out  64  read data returned to the owning master.
- s_addr  out  16  shared slave address.
- s_wr  out  1  shared slave write strobe.
- s_din  out  64  shared slave write data.
- s0_sel  out  1  slave 0 select.
- s1_sel  out  1  slave 1 select.
- s0_dout  in  64  slave 0 read data.
- s1_dout  in  64  slave 1 read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, both grants 0, hold_cnt=0, last=1, so m0 wins the first tie.
  - All bus outputs 0.
- FSM states: IDLE, GNT0, GNT1. Grants are decoded from the state register only; at most one grant is ever high.
- IDLE:
  - Only m0_req -> GNT0. Only m1_req -> GNT1.
  - Both requesting -> the master not equal to last (round-robin).
  - Neither -> stay in IDLE.
- GNTx:
  - mx_req low and my_req high -> GNTy. Direct handover, no idle bubble.
  - mx_req low and my_req low -> IDLE.
  - mx_req high -> stay, unless MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and my_req high; then -> GNTy.
- hold_cnt:
  - Increments each cycle in GNTx while my_req is high; otherwise holds at 0.
  - Clears on any state change. Saturates at MAX_HOLD-1.
- last: updates to x on every entry into GNTx.
- Latency: request seen at edge N; grant high after edge N. The request-to-grant minimum is 1 cycle.
- Releasing a grant: dropping mx_req at edge N deasserts mx_grant after edge N.
- Datapath (combinational from state):
  - Owner x drives s_addr=mx_addr, s_wr=mx_wr, s_din=mx_dout.
  - In IDLE: s_addr=0, s_wr=0, s_din=0.
- Slave decode (only while a grant is active):
  - s0_sel=1 iff s_addr[15:8]==S0_BASE[15:8].
  - s1_sel=1 iff s_addr[15:8]==S1_BASE[15:8].
  - Out-of-window address: both sels 0, s_wr forced 0, m_din=0.
- m_din:
  - s0_dout when s0_sel, s1_dout when s1_sel, else 0.
  - Non-owner masters must ignore m_din.
- Simultaneous events:
  - Owner drop and hold expiry in the same cycle -> handover to the other master.
  - Both masters dropping their request -> IDLE.
- Reset mid-transfer: the grant drops immediately and no write strobe survives. After reset, arbitration restarts with m0 priority.

Decomposition:
- Shared package bus_pkg:
  - state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2);
  - ADDR_W=16, DATA_W=64;
  - default slave base constants.
- One natural sub-module, bus_addr_dec: combinational decode of s_addr into s0_sel/s1_sel. It is reusable by the single-master bus.
- The arbiter FSM, hold counter and muxes stay in the top module.

Test Plan:
1. Reset, then m0_req=1, m0_wr=1, m0_addr=16'h0100, m0_dout=64'hFFFF_FFFF -> m0_grant=1 after the first edge; s1_sel=1, s_wr=1, s_din=64'hFFFF_FFFF.
2. Both requests rise in the same cycle after reset -> GNT0 first. m0 then drops with m1 still requesting -> m1_grant=1 on the next edge, with no IDLE cycle between grants.
3. m1 read at 16'h0010 with s0_dout=64'h5555_5555 -> s0_sel=1, s_wr=0, m_din=64'h5555_5555. The same read at 16'h0210 -> both sels 0, m_din=0.
4. m0 holds its request, m1 requests continuously, MAX_HOLD=8 -> m0_grant stays high exactly 8 cycles after m1_req rises, then m1_grant=1. With MAX_HOLD=0, m0 keeps the bus indefinitely.
5. Assert reset mid-write while m1 owns the bus at 16'h0110 -> m1_grant, s_wr, s1_sel go to 0 immediately. After release with both requesting -> m0 granted.
6. Single requester toggles m0_req 1,0,1 with one-cycle pulses -> states cycle GNT0, IDLE, GNT0, and m1_grant never asserts.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the 64-bit system bus: arbiter state encoding,
// bus widths, default slave windows and the owner-to-slave request payload.
package bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned PAGE_W = ADDR_W - OFF_W;

    localparam logic [ADDR_W-1:0] S0_BASE_DEF = 16'h0000;
    localparam logic [ADDR_W-1:0] S1_BASE_DEF = 16'h0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Request the current owner presents to the shared slave port
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

endpackage

// File: rtl/bus_addr_dec.sv
// Slave window decode: compares the upper address byte against each slave page.
// Shared with the single-master bus hookup.
module bus_addr_dec
    import bus_pkg::*;
#(
    parameter logic [PAGE_W-1:0] S0_PAGE = S0_BASE_DEF[ADDR_W-1:OFF_W],
    parameter logic [PAGE_W-1:0] S1_PAGE = S1_BASE_DEF[ADDR_W-1:OFF_W]
) (
    input  logic              en,
    input  logic [PAGE_W-1:0] page,
    output logic              s0_sel_c,
    output logic              s1_sel_c
);

    always_comb begin
        s0_sel_c = 1'b0;
        s1_sel_c = 1'b0;
        if (en) begin
            s0_sel_c = (page == S0_PAGE);
            s1_sel_c = (page == S1_PAGE) && (page != S0_PAGE);
        end
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter with bounded hold time, owner mux onto the
// shared slave port and slave select / read-data return.
module bus_arbiter_2m
    import bus_pkg::*;
#(
    parameter int unsigned       MAX_HOLD = 8,
    parameter logic [ADDR_W-1:0] S0_BASE  = S0_BASE_DEF,
    parameter logic [ADDR_W-1:0] S1_BASE  = S1_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m_din,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr,
    output logic [DATA_W-1:0] s_din,
    output logic              s0_sel,
    output logic              s1_sel,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout
);

    // Counter holds 0..MAX_HOLD-1; with MAX_HOLD==0 it never leaves 0
    localparam int unsigned HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    arb_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              last, last_nxt;
    logic              hold_at_lim;
    logic              hold_force;
    logic              other_req;
    bus_req_t          owner;
    logic              owner_act;
    logic              in_window;

    assign hold_at_lim = (hold_cnt == HOLD_W'(HOLD_LIM));
    assign hold_force  = (MAX_HOLD != 0) && hold_at_lim;
    assign other_req   = ((state == GNT0) && m1_req) || ((state == GNT1) && m0_req);

    // Next state, hold counter and round-robin pointer
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        last_nxt  = last;

        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_nxt = last ? GNT0 : GNT1;
                else if (m0_req)
                    state_nxt = GNT0;
                else if (m1_req)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_req)
                    state_nxt = m1_req ? GNT1 : IDLE;
                else if (hold_force && m1_req)
                    state_nxt = GNT1;
            end
            GNT1: begin
                if (!m1_req)
                    state_nxt = m0_req ? GNT0 : IDLE;
                else if (hold_force && m0_req)
                    state_nxt = GNT0;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == state && other_req)
            hold_nxt = hold_at_lim ? hold_cnt : hold_cnt + HOLD_W'(1);

        if (state_nxt != state) begin
            if (state_nxt == GNT0)
                last_nxt = 1'b0;
            else if (state_nxt == GNT1)
                last_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            m0_grant <= 1'b0;
            m1_grant <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
            m0_grant <= (state_nxt == GNT0);
            m1_grant <= (state_nxt == GNT1);
        end
    end

    // Owner request mux; idle bus is all zeros
    always_comb begin
        owner = '0;
        case (state)
            GNT0:    owner = '{wr: m0_wr, addr: m0_addr, data: m0_dout};
            GNT1:    owner = '{wr: m1_wr, addr: m1_addr, data: m1_dout};
            default: owner = '0;
        endcase
    end

    assign owner_act = (state == GNT0) || (state == GNT1);

    bus_addr_dec #(
        .S0_PAGE (S0_BASE[ADDR_W-1:OFF_W]),
        .S1_PAGE (S1_BASE[ADDR_W-1:OFF_W])
    ) u_dec (
        .en       (owner_act),
        .page     (owner.addr[ADDR_W-1:OFF_W]),
        .s0_sel_c (s0_sel),
        .s1_sel_c (s1_sel)
    );

    // Writes outside both windows are dropped
    assign in_window = s0_sel || s1_sel;
    assign s_addr    = owner.addr;
    assign s_din     = owner.data;
    assign s_wr      = owner.wr && in_window;

    always_comb begin
        m_din = '0;
        if (s0_sel)
            m_din = s0_dout;
        else if (s1_sel)
            m_din = s1_dout;
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: a vector table for arbitration and decode,
// plus hand sequences for hold expiry, mid-write reset and request pulsing.
module tb_bus_arbiter_2m;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [63:0] m0_dout, m1_dout;
    logic [63:0] s0_dout, s1_dout;

    logic        m0_grant, m1_grant, s_wr, s0_sel, s1_sel;
    logic [15:0] s_addr;
    logic [63:0] s_din, m_din;

    logic        nh_m0_grant, nh_m1_grant, nh_s_wr, nh_s0_sel, nh_s1_sel;
    logic [15:0] nh_s_addr;
    logic [63:0] nh_s_din, nh_m_din;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
        .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din),
        .s0_sel(s0_sel), .s1_sel(s1_sel), .s0_dout(s0_dout), .s1_dout(s1_dout)
    );

    bus_arbiter_2m #(.MAX_HOLD(0)) dut_nh (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m0_grant(nh_m0_grant), .m1_grant(nh_m1_grant), .m_din(nh_m_din),
        .s_addr(nh_s_addr), .s_wr(nh_s_wr), .s_din(nh_s_din),
        .s0_sel(nh_s0_sel), .s1_sel(nh_s1_sel), .s0_dout(s0_dout), .s1_dout(s1_dout)
    );

    typedef struct {
        logic        m0_req;
        logic        m0_wr;
        logic [15:0] m0_addr;
        logic [63:0] m0_dout;
        logic        m1_req;
        logic        m1_wr;
        logic [15:0] m1_addr;
        logic [63:0] m1_dout;
        logic        g0;
        logic        g1;
        logic [15:0] s_addr;
        logic        s_wr;
        logic [63:0] s_din;
        logic        s0_sel;
        logic        s1_sel;
        logic [63:0] m_din;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_wr = 0; m0_addr = '0; m0_dout = '0;
        m1_req = 0; m1_wr = 0; m1_addr = '0; m1_dout = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        s0_dout = 64'h5555_5555;
        s1_dout = 64'hAAAA_AAAA;
        clear_inputs();

        vecs[0]  = '{0,0,16'h0000,64'h0,          0,0,16'h0000,64'h0,    0,0,16'h0000,0,64'h0,          0,0,64'h0};
        vecs[1]  = '{1,1,16'h0100,64'hFFFF_FFFF,  0,0,16'h0000,64'h0,    1,0,16'h0100,1,64'hFFFF_FFFF,  0,1,64'hAAAA_AAAA};
        vecs[2]  = '{1,0,16'h0010,64'hFFFF_FFFF,  0,0,16'h0000,64'h0,    1,0,16'h0010,0,64'hFFFF_FFFF,  1,0,64'h5555_5555};
        vecs[3]  = '{1,1,16'h0210,64'hFFFF_FFFF,  0,0,16'h0000,64'h0,    1,0,16'h0210,0,64'hFFFF_FFFF,  0,0,64'h0};
        vecs[4]  = '{0,0,16'h0000,64'h0,          1,0,16'h0010,64'h1234, 0,1,16'h0010,0,64'h1234,       1,0,64'h5555_5555};
        vecs[5]  = '{0,0,16'h0000,64'h0,          1,0,16'h0210,64'h1234, 0,1,16'h0210,0,64'h1234,       0,0,64'h0};
        vecs[6]  = '{0,0,16'h0000,64'h0,          0,0,16'h0000,64'h0,    0,0,16'h0000,0,64'h0,          0,0,64'h0};
        vecs[7]  = '{1,0,16'h0100,64'h0,          1,1,16'h0110,64'h77,   1,0,16'h0100,0,64'h0,          0,1,64'hAAAA_AAAA};
        vecs[8]  = '{0,0,16'h0000,64'h0,          1,1,16'h0110,64'h77,   0,1,16'h0110,1,64'h77,         0,1,64'hAAAA_AAAA};
        vecs[9]  = '{0,0,16'h0000,64'h0,          0,0,16'h0000,64'h0,    0,0,16'h0000,0,64'h0,          0,0,64'h0};
        vecs[10] = '{1,1,16'h0000,64'h42,         1,0,16'h0110,64'h77,   1,0,16'h0000,1,64'h42,         1,0,64'h5555_5555};
        vecs[11] = '{0,0,16'h0000,64'h0,          0,0,16'h0000,64'h0,    0,0,16'h0000,0,64'h0,          0,0,64'h0};

        // Reset state
        do_reset();
        #1;
        chk("rst_g0", 64'(m0_grant), 64'd0);
        chk("rst_g1", 64'(m1_grant), 64'd0);
        chk("rst_swr", 64'(s_wr), 64'd0);
        chk("rst_saddr", 64'(s_addr), 64'd0);

        // Table: one vector per clock, outputs checked just after the edge
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            m0_req = vecs[i].m0_req; m0_wr = vecs[i].m0_wr;
            m0_addr = vecs[i].m0_addr; m0_dout = vecs[i].m0_dout;
            m1_req = vecs[i].m1_req; m1_wr = vecs[i].m1_wr;
            m1_addr = vecs[i].m1_addr; m1_dout = vecs[i].m1_dout;
            step();
            chk($sformatf("v%0d_g0", i), 64'(m0_grant), 64'(vecs[i].g0));
            chk($sformatf("v%0d_g1", i), 64'(m1_grant), 64'(vecs[i].g1));
            chk($sformatf("v%0d_saddr", i), 64'(s_addr), 64'(vecs[i].s_addr));
            chk($sformatf("v%0d_swr", i), 64'(s_wr), 64'(vecs[i].s_wr));
            chk($sformatf("v%0d_sdin", i), s_din, vecs[i].s_din);
            chk($sformatf("v%0d_s0sel", i), 64'(s0_sel), 64'(vecs[i].s0_sel));
            chk($sformatf("v%0d_s1sel", i), 64'(s1_sel), 64'(vecs[i].s1_sel));
            chk($sformatf("v%0d_mdin", i), m_din, vecs[i].m_din);
        end

        // Hold expiry: m0 keeps the bus exactly 8 cycles once m1 starts waiting
        begin
            int cnt;
            do_reset();
            @(negedge clk);
            m0_req = 1'b1;
            step();
            chk("hold_start_g0", 64'(m0_grant), 64'd1);
            m1_req = 1'b1;
            cnt = 1;
            for (int k = 0; k < 20; k++) begin
                step();
                if (!m0_grant) break;
                cnt++;
            end
            chk("hold_cycles", 64'(cnt), 64'd8);
            chk("hold_g1", 64'(m1_grant), 64'd1);
            chk("hold_g0_low", 64'(m0_grant), 64'd0);
            repeat (12) step();
            chk("nohold_g0", 64'(nh_m0_grant), 64'd1);
            chk("nohold_g1", 64'(nh_m1_grant), 64'd0);
        end

        // Reset in the middle of an m1 write, then tie after release goes to m0
        do_reset();
        @(negedge clk);
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0110; m1_dout = 64'h99;
        step();
        chk("mrst_pre_g1", 64'(m1_grant), 64'd1);
        chk("mrst_pre_swr", 64'(s_wr), 64'd1);
        chk("mrst_pre_s1sel", 64'(s1_sel), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mrst_g1", 64'(m1_grant), 64'd0);
        chk("mrst_swr", 64'(s_wr), 64'd0);
        chk("mrst_s1sel", 64'(s1_sel), 64'd0);
        @(negedge clk);
        m0_req = 1'b1;
        reset  = 1'b0;
        step();
        chk("mrst_post_g0", 64'(m0_grant), 64'd1);
        chk("mrst_post_g1", 64'(m1_grant), 64'd0);

        // Single requester pulsing: GNT0, IDLE, GNT0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m0_req = (k != 1);
            step();
            chk($sformatf("pulse%0d_g0", k), 64'(m0_grant), 64'(k != 1));
            chk($sformatf("pulse%0d_g1", k), 64'(m1_grant), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
